// File: rtl/oam_dma_controller.sv
// Sprite OAM DMA sequencer: a CPU write to TRIGGER_ADDR stalls the CPU and copies page
// {P,00..FF} to DEST_ADDR. Optional even-cycle alignment is enabled with OAM_DMA_ALIGN_EN.
module oam_dma_controller #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR    = 16'h2004
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cpu_rw,
    input  logic [15:0] i_cpu_address,
    input  logic [7:0]  i_cpu_data,
    output logic        o_cpu_rdy,
    output logic        o_rw,
    output logic [15:0] o_address,
    output logic [7:0]  o_data,
    input  logic [7:0]  i_data,
    output logic        o_active
);

`ifdef OAM_DMA_ALIGN_EN
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HALT, READ, WRITE} state_t;
`endif

    state_t      state_reg, state_next;
    logic [7:0]  page_reg, page_next;
    logic [7:0]  index_reg, index_next;
    logic [7:0]  buffer_reg, buffer_next;
    logic        rdy_reg, rdy_next;
    logic        active_reg, active_next;
    logic        parity_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg  <= IDLE;
            page_reg   <= 8'h00;
            index_reg  <= 8'h00;
            buffer_reg <= 8'h00;
            rdy_reg    <= 1'b1;
            active_reg <= 1'b0;
            parity_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            page_reg   <= page_next;
            index_reg  <= index_next;
            buffer_reg <= buffer_next;
            rdy_reg    <= rdy_next;
            active_reg <= active_next;
            parity_reg <= ~parity_reg;
        end
    end

    always_comb begin
        state_next  = state_reg;
        page_next   = page_reg;
        index_next  = index_reg;
        buffer_next = buffer_reg;
        rdy_next    = rdy_reg;
        active_next = active_reg;
        case (state_reg)
            IDLE: begin
                if (!i_cpu_rw && (i_cpu_address == TRIGGER_ADDR)) begin
                    state_next = HALT;
                    page_next  = i_cpu_data;
                    index_next = 8'h00;
                    rdy_next   = 1'b0;
                end
            end
            HALT: begin
                // The CPU only stops on a read, so keep passing its writes through.
                if (i_cpu_rw) begin
                    active_next = 1'b1;
`ifdef OAM_DMA_ALIGN_EN
                    // parity_reg==0 means the coming cycle is odd: burn it so READ lands even.
                    state_next = parity_reg ? READ : ALIGN;
`else
                    state_next = READ;
`endif
                end
            end
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: state_next = READ;
`endif
            READ: begin
                buffer_next = i_data;
                state_next  = WRITE;
            end
            WRITE: begin
                index_next = index_reg + 8'd1;
                if (index_reg == 8'hFF) begin
                    state_next  = IDLE;
                    rdy_next    = 1'b1;
                    active_next = 1'b0;
                end else begin
                    state_next = READ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_rw      = i_cpu_rw;
        o_address = i_cpu_address;
        o_data    = i_cpu_data;
        case (state_reg)
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: o_rw = 1'b1;
`endif
            READ: begin
                o_rw      = 1'b1;
                o_address = {page_reg, index_reg};
            end
            WRITE: begin
                o_rw      = 1'b0;
                o_address = DEST_ADDR;
                o_data    = buffer_reg;
            end
            default: ;
        endcase
    end

    assign o_cpu_rdy = rdy_reg;
    assign o_active  = active_reg;

endmodule
